// File: rtl/seq_match_pkg.sv
// Shared state encoding for the sequence-recognition FSM.
// The enum values double as the Status output encoding.
package seq_match_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'b000,
    S_ARMED  = 3'b001,
    S_MATCH  = 3'b010,
    S_LOCKED = 3'b011
  } state_t;

  localparam logic [STATE_W-1:0] STATUS_IDLE   = 3'b000;
  localparam logic [STATE_W-1:0] STATUS_ARMED  = 3'b001;
  localparam logic [STATE_W-1:0] STATUS_MATCH  = 3'b010;
  localparam logic [STATE_W-1:0] STATUS_LOCKED = 3'b011;

endpackage

// File: rtl/seq_match_timer.sv
// Idle-cycle counter that abandons a partial match after TIMEOUT quiet cycles.
// o_Tc fires on the edge where the count would reach TIMEOUT; the counter then restarts at zero.
module seq_match_timer
  import seq_match_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_Count;

  assign o_Tc = i_Enable && !i_Clear && (r_Count == CW'(TIMEOUT - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_Count <= '0;
    end else if (i_Clear || o_Tc) begin
      r_Count <= '0;
    end else if (i_Enable) begin
      r_Count <= r_Count + CW'(1);
    end
  end

endmodule

// File: rtl/seq_match_fsm.sv
// Run-time programmable sequence matcher: pulses Match on each complete pattern,
// locks after LOCK_AFTER matches, and drops partial matches after an idle timeout.
module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter int SYM_W      = 2,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 15,
  parameter int LOCK_AFTER = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         i_Start,
  input  logic                         i_ClearLock,
  input  logic [DEPTH*SYM_W-1:0]       i_Pattern,
  input  logic [SYM_W-1:0]             i_Sym,
  input  logic                         i_SymValid,
  output logic                         o_Armed,
  output logic                         o_Match,
  output logic                         o_Timeout,
  output logic                         o_Locked,
  output logic [$clog2(DEPTH+1)-1:0]   o_Progress,
  output logic [STATE_W-1:0]           o_Status
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(LOCK_AFTER + 1);

  state_t                 r_State;
  logic [DEPTH*SYM_W-1:0] r_Pattern;
  logic [PW-1:0]          r_Progress;
  logic [CW-1:0]          r_MatchCount;
  logic                   r_Timeout;

  state_t                 w_NextState;
  logic [PW-1:0]          w_NextProgress;
  logic [CW-1:0]          w_NextCount;
  logic [CW-1:0]          w_CountInc;
  logic                   w_LoadPattern;
  logic                   w_NextTimeout;
  logic                   w_TimerClear;
  logic                   w_TimerEnable;
  logic                   w_TimerTc;
  logic [SYM_W-1:0]       w_ExpSym;
  logic [SYM_W-1:0]       w_FirstSym;

  seq_match_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .i_Clear  (w_TimerClear),
    .i_Enable (w_TimerEnable),
    .o_Tc     (w_TimerTc)
  );

  // Select the pattern symbol the next accepted symbol must equal.
  always_comb begin
    w_ExpSym = r_Pattern[SYM_W-1:0];
    for (int k = 0; k < DEPTH; k++) begin
      if (r_Progress == PW'(k)) begin
        w_ExpSym = r_Pattern[k*SYM_W +: SYM_W];
      end
    end
  end

  assign w_FirstSym = r_Pattern[SYM_W-1:0];
  assign w_CountInc = r_MatchCount + CW'(1);

  // Next-state logic; Start re-arms from every legal state and beats symbols and timeout.
  always_comb begin
    w_NextState    = r_State;
    w_NextProgress = r_Progress;
    w_NextCount    = r_MatchCount;
    w_LoadPattern  = 1'b0;
    w_NextTimeout  = 1'b0;
    w_TimerClear   = 1'b1;
    w_TimerEnable  = 1'b0;

    case (r_State)
      S_IDLE: begin
        if (i_Start) begin
          w_NextState    = S_ARMED;
          w_LoadPattern  = 1'b1;
          w_NextProgress = '0;
          w_NextCount    = '0;
        end
      end
      S_ARMED: begin
        if (i_Start) begin
          w_LoadPattern  = 1'b1;
          w_NextProgress = '0;
          w_NextCount    = '0;
        end else if (i_SymValid) begin
          if (i_Sym == w_ExpSym) begin
            w_NextProgress = r_Progress + PW'(1);
            if (r_Progress == PW'(DEPTH - 1)) begin
              w_NextState = S_MATCH;
            end
          end else if (i_Sym == w_FirstSym) begin
            w_NextProgress = PW'(1);
          end else begin
            w_NextProgress = '0;
          end
        end else if (r_Progress != '0) begin
          w_TimerClear  = 1'b0;
          w_TimerEnable = 1'b1;
          if (w_TimerTc) begin
            w_NextProgress = '0;
            w_NextTimeout  = 1'b1;
          end
        end
      end
      S_MATCH: begin
        w_NextProgress = '0;
        if (i_Start) begin
          w_NextState   = S_ARMED;
          w_LoadPattern = 1'b1;
          w_NextCount   = '0;
        end else begin
          w_NextCount = w_CountInc;
          w_NextState = (w_CountInc == CW'(LOCK_AFTER)) ? S_LOCKED : S_ARMED;
        end
      end
      S_LOCKED: begin
        if (i_Start) begin
          w_NextState    = S_ARMED;
          w_LoadPattern  = 1'b1;
          w_NextProgress = '0;
          w_NextCount    = '0;
        end else if (i_ClearLock) begin
          w_NextState = S_IDLE;
        end
      end
      default: begin
        w_NextState    = S_IDLE;
        w_NextProgress = '0;
        w_NextCount    = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_State      <= S_IDLE;
      r_Pattern    <= '0;
      r_Progress   <= '0;
      r_MatchCount <= '0;
      r_Timeout    <= 1'b0;
    end else begin
      r_State      <= w_NextState;
      r_Progress   <= w_NextProgress;
      r_MatchCount <= w_NextCount;
      r_Timeout    <= w_NextTimeout;
      if (w_LoadPattern) begin
        r_Pattern <= i_Pattern;
      end
    end
  end

  assign o_Armed    = (r_State == S_ARMED);
  assign o_Match    = (r_State == S_MATCH);
  assign o_Locked   = (r_State == S_LOCKED);
  assign o_Status   = r_State;
  assign o_Progress = r_Progress;
  assign o_Timeout  = r_Timeout;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Directed-vector bench for seq_match_fsm with SYM_W=2, DEPTH=4, TIMEOUT=5, LOCK_AFTER=2.
// Pattern 8'h27 presents symbols in the order 3,1,2,0.
module tb_seq_match_fsm;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       i_Start;
  logic       i_ClearLock;
  logic [7:0] i_Pattern;
  logic [1:0] i_Sym;
  logic       i_SymValid;
  logic       o_Armed;
  logic       o_Match;
  logic       o_Timeout;
  logic       o_Locked;
  logic [2:0] o_Progress;
  logic [2:0] o_Status;

  int total = 0;
  int bad   = 0;

  seq_match_fsm #(
    .SYM_W(2), .DEPTH(4), .TIMEOUT(5), .LOCK_AFTER(2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_Start     (i_Start),
    .i_ClearLock (i_ClearLock),
    .i_Pattern   (i_Pattern),
    .i_Sym       (i_Sym),
    .i_SymValid  (i_SymValid),
    .o_Armed     (o_Armed),
    .o_Match     (o_Match),
    .o_Timeout   (o_Timeout),
    .o_Locked    (o_Locked),
    .o_Progress  (o_Progress),
    .o_Status    (o_Status)
  );

  always #5 Clock = ~Clock;

  // Drive one cycle of inputs and settle just after the rising edge.
  task automatic applyStimulus(input logic start, input logic valid, input logic [1:0] sym);
    i_Start    = start;
    i_SymValid = valid;
    i_Sym      = sym;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    i_ClearLock = 1'b0;
    i_Pattern = 8'h27;
    applyStimulus(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd3);
    Reset = 1'b0;
    total++; if (o_Status !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", o_Status); end
    total++; if ({o_Armed, o_Match, o_Timeout, o_Locked} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {o_Armed, o_Match, o_Timeout, o_Locked}); end
    total++; if (o_Progress !== 3'd0) begin bad++; $display("FAIL reset_progress: got %0d want 0", o_Progress); end
  endtask

  task automatic test_basic_match();
    logic [1:0] syms [4];
    int         expP [4];
    syms = '{2'd3, 2'd1, 2'd2, 2'd0};
    expP = '{1, 2, 3, 4};
    i_Pattern = 8'h27;
    applyStimulus(1'b1, 1'b0, 2'd0);
    total++; if (o_Status !== 3'b001) begin bad++; $display("FAIL basic_armed_status: got %b want 001", o_Status); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, syms[i]);
      total++; if (o_Progress !== expP[i]) begin bad++; $display("FAIL basic_progress[%0d]: got %0d want %0d", i, o_Progress, expP[i]); end
      total++; if (o_Match !== (i == 3)) begin bad++; $display("FAIL basic_match[%0d]: got %b want %b", i, o_Match, (i == 3)); end
    end
    total++; if (o_Status !== 3'b010) begin bad++; $display("FAIL basic_match_status: got %b want 010", o_Status); end
    applyStimulus(1'b0, 1'b0, 2'd0);
    total++; if (o_Status !== 3'b001) begin bad++; $display("FAIL basic_after_status: got %b want 001", o_Status); end
    total++; if (o_Match !== 1'b0) begin bad++; $display("FAIL basic_after_match: got %b want 0", o_Match); end
    total++; if (o_Progress !== 3'd0) begin bad++; $display("FAIL basic_after_progress: got %0d want 0", o_Progress); end
  endtask

  task automatic test_restart_on_mismatch();
    logic [1:0] syms [6];
    int         expP [6];
    int         pulses;
    syms = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd0};
    expP = '{1, 2, 1, 2, 3, 4};
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, syms[i]);
      if (o_Match === 1'b1) pulses++;
      total++; if (o_Progress !== expP[i]) begin bad++; $display("FAIL restart_progress[%0d]: got %0d want %0d", i, o_Progress, expP[i]); end
    end
    total++; if (o_Match !== 1'b1) begin bad++; $display("FAIL restart_final_match: got %b want 1", o_Match); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL restart_pulse_count: got %0d want 1", pulses); end
    applyStimulus(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd3);
    total++; if (o_Progress !== 3'd1) begin bad++; $display("FAIL timeout_progress_start: got %0d want 1", o_Progress); end
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0);
      if (o_Timeout === 1'b1) pulses++;
      total++; if (o_Timeout !== (i == 5)) begin bad++; $display("FAIL timeout_pulse[%0d]: got %b want %b", i, o_Timeout, (i == 5)); end
      total++; if (o_Match !== 1'b0) begin bad++; $display("FAIL timeout_no_match[%0d]: got %b want 0", i, o_Match); end
    end
    total++; if (o_Progress !== 3'd0) begin bad++; $display("FAIL timeout_progress_cleared: got %0d want 0", o_Progress); end
    total++; if (o_Armed !== 1'b1) begin bad++; $display("FAIL timeout_armed: got %b want 1", o_Armed); end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0);
      if (o_Timeout === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL timeout_pulse_count: got %0d want 1", pulses); end
  endtask

  task automatic test_lock();
    logic [1:0] syms [4];
    int         pulses;
    syms = '{2'd3, 2'd1, 2'd2, 2'd0};
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, syms[i]);
      total++; if (o_Match !== 1'b1) begin bad++; $display("FAIL lock_match[%0d]: got %b want 1", m, o_Match); end
      applyStimulus(1'b0, 1'b0, 2'd0);
    end
    total++; if (o_Locked !== 1'b1) begin bad++; $display("FAIL lock_locked: got %b want 1", o_Locked); end
    total++; if (o_Status !== 3'b011) begin bad++; $display("FAIL lock_status: got %b want 011", o_Status); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, syms[i]);
      if (o_Match === 1'b1) pulses++;
    end
    applyStimulus(1'b0, 1'b0, 2'd0);
    if (o_Match === 1'b1) pulses++;
    total++; if (pulses !== 0) begin bad++; $display("FAIL lock_sticky_no_match: got %0d pulses want 0", pulses); end
    total++; if (o_Locked !== 1'b1) begin bad++; $display("FAIL lock_sticky: got %b want 1", o_Locked); end
    i_ClearLock = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0);
    i_ClearLock = 1'b0;
    total++; if (o_Status !== 3'b000) begin bad++; $display("FAIL lock_clear_status: got %b want 000", o_Status); end
    total++; if (o_Locked !== 1'b0) begin bad++; $display("FAIL lock_clear_locked: got %b want 0", o_Locked); end
  endtask

  task automatic test_start_priority();
    logic [1:0] syms [4];
    syms = '{2'd0, 2'd1, 2'd2, 2'd3};
    i_Pattern = 8'h27;
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 2'd2);
    total++; if (o_Progress !== 3'd3) begin bad++; $display("FAIL start_pre_progress: got %0d want 3", o_Progress); end
    i_ClearLock = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0);
    i_ClearLock = 1'b0;
    total++; if ({o_Status, o_Progress} !== {3'b001, 3'd3}) begin bad++; $display("FAIL start_clearlock_ignored: got %b/%0d want 001/3", o_Status, o_Progress); end
    i_Pattern = 8'hE4;
    applyStimulus(1'b1, 1'b1, 2'd0);
    total++; if (o_Match !== 1'b0) begin bad++; $display("FAIL start_no_match: got %b want 0", o_Match); end
    total++; if (o_Progress !== 3'd0) begin bad++; $display("FAIL start_progress: got %0d want 0", o_Progress); end
    i_Pattern = 8'h27;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, syms[i]);
    total++; if (o_Match !== 1'b1) begin bad++; $display("FAIL start_reloaded_match: got %b want 1", o_Match); end
    applyStimulus(1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_reset_mid_match();
    logic [1:0] syms [4];
    int         responses;
    syms = '{2'd3, 2'd1, 2'd2, 2'd0};
    responses = 0;
    i_Pattern = 8'h27;
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1, 2'd1);
    total++; if (o_Progress !== 3'd2) begin bad++; $display("FAIL midreset_pre_progress: got %0d want 2", o_Progress); end
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'd2);
    Reset = 1'b0;
    total++; if ({o_Status, o_Progress, o_Armed, o_Match, o_Timeout, o_Locked} !== 10'b0) begin bad++; $display("FAIL midreset_outputs: got %b want 0", {o_Status, o_Progress, o_Armed, o_Match, o_Timeout, o_Locked}); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, syms[i]);
      if (o_Status !== 3'b000 || o_Progress !== 3'd0 || o_Match !== 1'b0) responses++;
    end
    total++; if (responses !== 0) begin bad++; $display("FAIL midreset_idle_ignores: got %0d responses want 0", responses); end
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, syms[i]);
    total++; if (o_Match !== 1'b1) begin bad++; $display("FAIL midreset_rearm_match: got %b want 1", o_Match); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Start = 1'b0; i_SymValid = 1'b0; i_Sym = 2'd0;
    test_reset();
    test_basic_match();
    test_restart_on_mismatch();
    test_timeout();
    test_lock();
    test_start_priority();
    test_reset_mid_match();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_fsm.md
Name: seq_match_fsm

Overview:
Parametrised sequence-recognition FSM, the successor to the fixed 5-state A/B control FSM. It tracks a run-time programmable pattern of DEPTH symbols, each SYM_W bits wide, on a qualified symbol stream. It pulses on each complete match and locks after a configurable number of matches. An idle-timeout abandons partial matches. It sits in the control path between the input conditioning logic and the downstream sequencer, which consumes Match, Locked and Status.

Parameters:
SYM_W, 2, symbol width in bits (legal: >=1)
DEPTH, 4, pattern length in symbols (legal: >=2)
TIMEOUT, 15, idle cycles allowed between symbols once Progress>0 (legal: >=1)
LOCK_AFTER, 2, matches required before entering LOCKED (legal: >=1)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Start  in  1  arm / re-arm; samples Pattern
ClearLock  in  1  leave LOCKED, return to IDLE
Pattern  in  DEPTH*SYM_W  symbol k = bits [k*SYM_W +: SYM_W]; symbol 0 is matched first
Sym  in  SYM_W  input symbol
SymValid  in  1  Sym qualifier
Armed  out  1  high in ARMED
Match  out  1  one-cycle pulse; high while in MATCH
Timeout  out  1  one-cycle registered pulse on idle timeout
Locked  out  1  high in LOCKED
Progress  out  clog2(DEPTH+1)  count of symbols matched so far
Status  out  3  encoded state

Behaviour:
- Reset and clock: Clock and Reset are as decided; Reset is synchronous, active-high, and dominates every other input.
- Reset values: state IDLE; Armed=0; Match=0; Timeout=0; Locked=0; Progress=0; match count=0; idle counter=0; pattern register=0.
- States and Status encoding: IDLE=000, ARMED=001, MATCH=010, LOCKED=011. Encodings 100-111 are illegal and return to IDLE on the next edge.
- IDLE:
  - Start=1 -> ARMED.
  - On the same edge: latch Pattern, clear Progress, match count and idle counter.
  - Sym is ignored.
- ARMED, SymValid=1 (symbol accepted on the edge):
  - Sym == pat[Progress]: Progress+1.
  - Mismatch and Sym == pat[0]: Progress=1.
  - Otherwise: Progress=0.
  - No longer-suffix (KMP) recovery is performed.
  - When an accepted symbol makes Progress reach DEPTH, the next state is MATCH. Progress then reads DEPTH during MATCH.
  - Match latency: Match is high in the cycle after the final symbol's accepting edge.
- ARMED, idle counter:
  - Counts cycles with SymValid=0 while Progress>0.
  - Clears on any accepted symbol and whenever Progress=0.
  - When the counter reaches TIMEOUT: Progress=0, counter=0, Timeout pulses high for exactly one cycle. State stays ARMED.
- MATCH (lasts exactly one cycle):
  - Match count increments on exit.
  - If the incremented count == LOCK_AFTER -> LOCKED.
  - Otherwise -> ARMED with Progress=0 (non-overlapping matching).
  - Sym and SymValid are ignored during MATCH.
- LOCKED:
  - Sticky; Sym is ignored.
  - ClearLock=1 -> IDLE.
  - Start=1 -> ARMED with a full re-arm (Start wins over ClearLock).
- Start in ARMED or MATCH: re-arm. Reload Pattern, Progress=0, match count=0, idle counter=0, next state ARMED. Start has priority over symbol acceptance and over timeout in the same cycle.
- ClearLock outside LOCKED: no effect.
- Outputs: Armed, Match, Locked and Status decode the state register and are glitch-free from registers. Timeout is a registered pulse.
- Match count width: clog2(LOCK_AFTER+1). Idle counter width: clog2(TIMEOUT+1). No counter wraps.
- Reset mid-match: returns to IDLE; the pattern must be re-armed with Start.

Decomposition:
- Package seq_match_pkg: state localparams (S_IDLE, S_ARMED, S_MATCH, S_LOCKED) and the Status encodings.
- One sub-module, seq_match_timer: the idle counter with clear/enable inputs and a terminal-count pulse, parametrised by TIMEOUT.
- The pattern compare and the FSM stay in the top module.

Test Plan:
All tests use SYM_W=2, DEPTH=4, TIMEOUT=5, LOCK_AFTER=2 and Pattern=8'h27 (symbol order 3,1,2,0).
1. Start; then symbols 3,1,2,0 on consecutive cycles -> Progress 1,2,3,4; Match=1 for one cycle; Status 010 then 001; Progress=0.
2. Start; symbols 3,1,3,1,2,0 -> Progress 1,2,1,2,3,4; a single Match pulse after the last symbol.
3. Start; symbol 3; SymValid=0 for 5 cycles -> Timeout pulses once; Progress=0; Armed stays 1; no Match.
4. Two complete matches -> second Match pulse, then Locked=1 and Status=011. Further valid 3,1,2,0 -> no Match. ClearLock -> Status=000, Locked=0.
5. Start asserted while Progress=3 and SymValid=1 with Sym=0 on the same edge -> no Match; Progress=0; Pattern reloaded.
6. Reset asserted while Progress=2 -> next cycle Status=000 and all outputs at their reset values. Symbols afterwards -> no response until Start.
